// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU sequencer: opcodes, FSM states and the
// per-operation ALU control tuples.
package alu_ctrl_pkg;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpAnd  = 4'h2;
  localparam logic [3:0] OpNand = 4'h3;
  localparam logic [3:0] OpOr   = 4'h4;
  localparam logic [3:0] OpNor  = 4'h5;
  localparam logic [3:0] OpXor  = 4'h6;
  localparam logic [3:0] OpXnor = 4'h7;
  localparam logic [3:0] OpAdd  = 4'h8;
  localparam logic [3:0] OpSub  = 4'h9;
  localparam logic [3:0] OpAdc  = 4'hA;
  localparam logic [3:0] OpShr  = 4'hB;
  localparam logic [3:0] OpShl  = 4'hC;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StWb    = 2'd3;

  typedef struct packed {
    logic [2:0] opsel;
    logic       a_inv;
    logic       x_inv;
    logic       op_inv;
  } alu_ctrl_t;

  localparam alu_ctrl_t CtrlNone = '{opsel: 3'd0, a_inv: 1'b0, x_inv: 1'b0, op_inv: 1'b0};
  localparam alu_ctrl_t CtrlAnd  = '{opsel: 3'd0, a_inv: 1'b0, x_inv: 1'b0, op_inv: 1'b0};
  localparam alu_ctrl_t CtrlNand = '{opsel: 3'd0, a_inv: 1'b0, x_inv: 1'b0, op_inv: 1'b1};
  localparam alu_ctrl_t CtrlOr   = '{opsel: 3'd0, a_inv: 1'b1, x_inv: 1'b1, op_inv: 1'b1};
  localparam alu_ctrl_t CtrlNor  = '{opsel: 3'd0, a_inv: 1'b1, x_inv: 1'b1, op_inv: 1'b0};
  localparam alu_ctrl_t CtrlXor  = '{opsel: 3'd1, a_inv: 1'b0, x_inv: 1'b0, op_inv: 1'b0};
  localparam alu_ctrl_t CtrlXnor = '{opsel: 3'd1, a_inv: 1'b0, x_inv: 1'b0, op_inv: 1'b1};
  localparam alu_ctrl_t CtrlAdd  = '{opsel: 3'd2, a_inv: 1'b0, x_inv: 1'b0, op_inv: 1'b0};
  localparam alu_ctrl_t CtrlSub  = '{opsel: 3'd2, a_inv: 1'b0, x_inv: 1'b1, op_inv: 1'b1};
  localparam alu_ctrl_t CtrlShr  = '{opsel: 3'd3, a_inv: 1'b0, x_inv: 1'b0, op_inv: 1'b1};
  localparam alu_ctrl_t CtrlShl  = '{opsel: 3'd2, a_inv: 1'b0, x_inv: 1'b0, op_inv: 1'b1};

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: ALU control tuple plus classification of the
// opcode as ALU op, load-immediate or illegal.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output alu_ctrl_t  ctrl,
  output logic       is_alu,
  output logic       is_ldi,
  output logic       is_illegal,
  output logic       use_carry,
  output logic       x_from_acc
);

  always_comb begin
    ctrl       = CtrlNone;
    is_alu     = 1'b1;
    is_ldi     = 1'b0;
    is_illegal = 1'b0;
    use_carry  = 1'b0;
    x_from_acc = 1'b0;
    case (op)
      OpNop:  is_alu = 1'b0;
      OpLdi: begin
        is_alu = 1'b0;
        is_ldi = 1'b1;
      end
      OpAnd:  ctrl = CtrlAnd;
      OpNand: ctrl = CtrlNand;
      OpOr:   ctrl = CtrlOr;
      OpNor:  ctrl = CtrlNor;
      OpXor:  ctrl = CtrlXor;
      OpXnor: ctrl = CtrlXnor;
      OpAdd:  ctrl = CtrlAdd;
      OpSub:  ctrl = CtrlSub;
      OpAdc: begin
        ctrl      = CtrlAdd;
        use_carry = 1'b1;
      end
      OpShr:  ctrl = CtrlShr;
      OpShl: begin
        // Shift left is acc + acc, so the X operand is the accumulator.
        ctrl       = CtrlShl;
        x_from_acc = 1'b1;
      end
      default: begin
        is_alu     = 1'b0;
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Instruction sequencer driving an external registered ALU: accepts one
// instruction at a time and writes the ALU result back into the accumulator.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CARRY_IDX = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [3:0] instr_op,
  input  logic [7:0] instr_imm,
  output logic       instr_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_x,
  output logic [2:0] alu_opsel,
  output logic       alu_a_inv,
  output logic       alu_x_inv,
  output logic       alu_op_inv,
  output logic       alu_carry,
  input  logic [7:0] alu_z,
  input  logic [7:0] alu_flags,
  output logic [7:0] acc,
  output logic [7:0] flags_q,
  output logic       done,
  output logic       illegal
);

  localparam logic [2:0] CarryBit = 3'(CARRY_IDX);

  logic [1:0] state_q, state_d;
  logic [3:0] op_q;
  logic [7:0] imm_q;
  logic       done_q;
  logic       accept;
  logic       active;

  logic [3:0] dec_op;
  alu_ctrl_t  dec_ctrl;
  logic       dec_alu, dec_ldi, dec_illegal, dec_carry, dec_x_acc;

  // In IDLE the decoder classifies the offered opcode; otherwise it holds the latched one.
  assign dec_op = (state_q == StIdle) ? instr_op : op_q;

  alu_op_decode u_decode (
    .op         (dec_op),
    .ctrl       (dec_ctrl),
    .is_alu     (dec_alu),
    .is_ldi     (dec_ldi),
    .is_illegal (dec_illegal),
    .use_carry  (dec_carry),
    .x_from_acc (dec_x_acc)
  );

  assign instr_ready = (state_q == StIdle) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign active      = (state_q == StIssue) || (state_q == StWait);
  assign done        = done_q || (state_q == StWb);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept && dec_alu) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  state_d = StWb;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 4'd0;
      imm_q   <= 8'd0;
      acc     <= 8'd0;
      flags_q <= 8'd0;
      done_q  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= accept && !dec_alu;
      if (accept) begin
        op_q  <= instr_op;
        imm_q <= instr_imm;
      end
      if (accept && dec_ldi) acc <= instr_imm;
      if (accept && dec_illegal) illegal <= 1'b1;
      if (state_q == StWb) begin
        acc     <= alu_z;
        flags_q <= alu_flags;
      end
    end
  end

  always_comb begin
    alu_a      = acc;
    alu_x      = imm_q;
    alu_opsel  = 3'd0;
    alu_a_inv  = 1'b0;
    alu_x_inv  = 1'b0;
    alu_op_inv = 1'b0;
    alu_carry  = 1'b0;
    if (active) begin
      alu_opsel  = dec_ctrl.opsel;
      alu_a_inv  = dec_ctrl.a_inv;
      alu_x_inv  = dec_ctrl.x_inv;
      alu_op_inv = dec_ctrl.op_inv;
      alu_carry  = dec_carry && flags_q[CarryBit];
      if (dec_x_acc) alu_x = acc;
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: registered ALU environment model, an
// instruction-level reference model, directed cases and random stimulus.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  localparam int unsigned CIDX = 3;
  localparam int unsigned ZIDX = (CIDX + 1) % 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [3:0] instr_op = 4'd0;
  logic [7:0] instr_imm = 8'd0;
  logic       instr_ready;
  logic [7:0] alu_a, alu_x, acc, flags_q;
  logic [2:0] alu_opsel;
  logic       alu_a_inv, alu_x_inv, alu_op_inv, alu_carry, done, illegal;
  logic [7:0] alu_z = 8'd0;
  logic [7:0] alu_flags = 8'd0;

  int checks = 0;
  int errors = 0;

  alu_ctrl #(.CARRY_IDX(CIDX)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_op    (instr_op),
    .instr_imm   (instr_imm),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_x       (alu_x),
    .alu_opsel   (alu_opsel),
    .alu_a_inv   (alu_a_inv),
    .alu_x_inv   (alu_x_inv),
    .alu_op_inv  (alu_op_inv),
    .alu_carry   (alu_carry),
    .alu_z       (alu_z),
    .alu_flags   (alu_flags),
    .acc         (acc),
    .flags_q     (flags_q),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External ALU: interprets the control tuple; result and flags registered on clk.
  function automatic logic [8:0] alu_env(input logic [2:0] sel, input logic ai, input logic xi,
                                         input logic oi, input logic ci,
                                         input logic [7:0] a, input logic [7:0] x);
    logic [7:0] a2, x2, r;
    logic       c;
    logic [8:0] s;
    a2 = ai ? ~a : a;
    x2 = xi ? ~x : x;
    r  = 8'd0;
    c  = 1'b0;
    case (sel)
      3'd0: r = oi ? ~(a2 & x2) : (a2 & x2);
      3'd1: r = oi ? ~(a2 ^ x2) : (a2 ^ x2);
      3'd2: begin
        s = {1'b0, a2} + {1'b0, x2} + {8'd0, ci | xi};
        r = s[7:0];
        c = s[8];
      end
      3'd3: begin
        r = a2 >> 1;
        c = a2[0];
      end
      default: ;
    endcase
    return {c, r};
  endfunction

  function automatic logic [7:0] mk_flags(input logic [8:0] cz);
    logic [7:0] f;
    f       = 8'd0;
    f[CIDX] = cz[8];
    f[ZIDX] = (cz[7:0] == 8'd0);
    return f;
  endfunction

  logic [8:0] env_cz;
  always @(posedge clk) begin
    env_cz = alu_env(alu_opsel, alu_a_inv, alu_x_inv, alu_op_inv, alu_carry, alu_a, alu_x);
    alu_z     <= env_cz[7:0];
    alu_flags <= mk_flags(env_cz);
  end

  // Instruction semantics: {carry, result}.
  function automatic logic [8:0] isa(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] x, input logic cin);
    case (op)
      OpAnd:  return {1'b0, a & x};
      OpNand: return {1'b0, ~(a & x)};
      OpOr:   return {1'b0, a | x};
      OpNor:  return {1'b0, ~(a | x)};
      OpXor:  return {1'b0, a ^ x};
      OpXnor: return {1'b0, ~(a ^ x)};
      OpAdd:  return {1'b0, a} + {1'b0, x};
      OpSub:  return {a >= x, a - x};
      OpAdc:  return {1'b0, a} + {1'b0, x} + {8'd0, cin};
      OpShr:  return {a[0], a >> 1};
      OpShl:  return {a[7], a << 1};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [5:0] exp_ctrl(input logic [3:0] op);
    case (op)
      OpNand:        return 6'b000_001;
      OpOr:          return 6'b000_111;
      OpNor:         return 6'b000_110;
      OpXor:         return 6'b001_000;
      OpXnor:        return 6'b001_001;
      OpAdd, OpAdc:  return 6'b010_000;
      OpSub:         return 6'b010_011;
      OpShr:         return 6'b011_001;
      OpShl:         return 6'b010_001;
      default:       return 6'b000_000;
    endcase
  endfunction

  // Reference model: m_busy counts remaining cycles of an ALU op (3 ISSUE, 2 WAIT, 1 WB).
  logic [7:0] m_acc, m_flags, m_imm, m_res_z, m_res_f;
  logic [3:0] m_op;
  logic       m_ill, m_pulse;
  logic [8:0] m_cz;
  int         m_busy;
  logic       m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_acc = 8'd0; m_flags = 8'd0; m_imm = 8'd0; m_op = 4'd0;
      m_ill = 1'b0; m_pulse = 1'b0; m_busy = 0; m_live = 1'b1;
    end else if (m_live) begin
      m_pulse = 1'b0;
      if (m_busy == 1) begin
        m_acc   = m_res_z;
        m_flags = m_res_f;
      end
      if (m_busy > 0) m_busy--;
      else if (instr_valid) begin
        m_op  = instr_op;
        m_imm = instr_imm;
        if (instr_op >= OpAnd && instr_op <= OpShl) begin
          m_cz    = isa(instr_op, m_acc, instr_imm, m_flags[CIDX]);
          m_res_z = m_cz[7:0];
          m_res_f = mk_flags(m_cz);
          m_busy  = 3;
        end else begin
          m_pulse = 1'b1;
          if (instr_op == OpLdi) m_acc = instr_imm;
          else if (instr_op != OpNop) m_ill = 1'b1;
        end
      end
    end
  end

  logic       c_act;
  logic [5:0] c_ec;
  always @(negedge clk) begin
    if (m_live) begin
      c_act = (m_busy == 3) || (m_busy == 2);
      c_ec  = c_act ? exp_ctrl(m_op) : 6'd0;
      chk("ready", instr_ready, (m_busy == 0) && !rst);
      chk("acc", acc, m_acc);
      chk("flags_q", flags_q, m_flags);
      chk("illegal", illegal, m_ill);
      chk("done", done, m_pulse || (m_busy == 1));
      chk("alu_a", alu_a, m_acc);
      chk("alu_x", alu_x, (c_act && m_op == OpShl) ? m_acc : m_imm);
      chk("alu_ctrl", {alu_opsel, alu_a_inv, alu_x_inv, alu_op_inv}, c_ec);
      chk("alu_carry", alu_carry, (c_act && m_op == OpAdc) ? m_flags[CIDX] : 1'b0);
    end
  end

  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] imm);
    @(negedge clk);
    #2;
    instr_valid = v;
    instr_op    = op;
    instr_imm   = imm;
  endtask

  // Returns 2 time units after the first falling edge following the accept edge.
  task automatic send(input logic [3:0] op, input logic [7:0] imm);
    int   n;
    logic r;
    n = 0;
    r = 1'b0;
    while (!r && n < 20) begin
      drive(1'b1, op, imm);
      r = instr_ready;
      @(posedge clk);
      n++;
    end
    chk("accept_timeout", r, 1'b1);
    drive(1'b0, op, imm);
  endtask

  task automatic run(input logic [3:0] op, input logic [7:0] imm, output int lat,
                     output logic [5:0] ctl, output logic [7:0] ax);
    send(op, imm);
    ctl = {alu_opsel, alu_a_inv, alu_x_inv, alu_op_inv};
    ax  = alu_x;
    lat = 1;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!instr_ready && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", instr_ready, 1'b1);
  endtask

  int         lat, ndone;
  logic [5:0] ctl;
  logic [7:0] ax;
  logic       r;
  int         edges[$];

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_acc", acc, 8'h00);
    chk("rst_flags", flags_q, 8'h00);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_done", done, 1'b0);

    run(OpLdi, 8'hAA, lat, ctl, ax);
    chk("ldi_lat", lat, 1);
    wait_idle();
    chk("ldi_acc", acc, 8'hAA);
    run(OpAnd, 8'h33, lat, ctl, ax);
    chk("and_ctl", ctl, 6'b000_000);
    chk("and_lat", lat, 3);
    wait_idle();
    chk("and_acc", acc, 8'h22);

    run(OpLdi, 8'hAA, lat, ctl, ax);
    run(OpOr, 8'h33, lat, ctl, ax);
    chk("or_ctl", ctl, 6'b000_111);
    wait_idle();
    chk("or_acc", acc, 8'hBB);

    run(OpLdi, 8'hAA, lat, ctl, ax);
    run(OpXnor, 8'h33, lat, ctl, ax);
    wait_idle();
    chk("xnor_acc", acc, 8'h66);

    run(OpLdi, 8'hAA, lat, ctl, ax);
    run(OpSub, 8'h33, lat, ctl, ax);
    chk("sub_ctl", ctl, 6'b010_011);
    wait_idle();
    chk("sub_acc", acc, 8'h77);

    run(OpLdi, 8'hAA, lat, ctl, ax);
    run(OpShl, 8'h00, lat, ctl, ax);
    chk("shl_x", ax, 8'hAA);
    wait_idle();
    chk("shl_acc", acc, 8'h54);

    // Valid held high across three ADDs: only IDLE cycles may accept.
    run(OpLdi, 8'h00, lat, ctl, ax);
    wait_idle();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, OpAdd, 8'h01);
      r = instr_ready;
      @(posedge clk);
      if (r) edges.push_back(i);
    end
    drive(1'b0, OpNop, 8'h00);
    wait_idle();
    chk("b2b_count", edges.size(), 3);
    if (edges.size() == 3) begin
      chk("b2b_gap1", edges[1] - edges[0], 4);
      chk("b2b_gap2", edges[2] - edges[1], 4);
    end
    chk("b2b_acc", acc, 8'h03);

    run(4'hE, 8'h55, lat, ctl, ax);
    chk("ill_lat", lat, 1);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_acc", acc, 8'h03);

    // Reset during WAIT of an ADD abandons it.
    send(OpAdd, 8'h05);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    ndone = 0;
    @(negedge clk);
    chk("rstw_ready", instr_ready, 1'b1);
    chk("rstw_acc", acc, 8'h00);
    chk("rstw_ill", illegal, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("rstw_no_done", ndone, 0);
    chk("rstw_acc_late", acc, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #2;
      rst         = ($urandom_range(0, 299) == 0);
      instr_valid = ($urandom_range(0, 99) < 50);
      instr_op    = 4'($urandom_range(0, 15));
      instr_imm   = 8'($urandom);
    end
    @(negedge clk);
    #2;
    rst         = 1'b0;
    instr_valid = 1'b0;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
